// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: assembles a little-endian byte stream
// into 32-bit words, writes them at consecutive word addresses, then releases the CPU.
module imem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int          WI_W      = $clog2(DEPTH) + 1;
    localparam logic [16:0] DEPTH_LIM = 17'(DEPTH);

    typedef enum logic [2:0] {
        S_CNT0,
        S_CNT1,
        S_DATA,
        S_FIN,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state, state_d;
    logic [1:0]        bi, bi_d;
    logic [WI_W-1:0]   wi, wi_d;
    logic [15:0]       cnt, cnt_d;
    logic [23:0]       asm_q, asm_d;
    logic              wr_en_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [31:0]       wr_data_d;
    logic              accept;
    logic [15:0]       n_rx;
    logic              last_word;

    assign in_ready  = (state == S_CNT0) || (state == S_CNT1) || (state == S_DATA);
    assign accept    = in_valid && in_ready;
    assign n_rx      = {in_data, cnt[7:0]};
    assign last_word = ((16'(wi) + 16'd1) == cnt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_CNT0;
        end else begin
            state <= state_d;
        end
    end

    // Only the lower three bytes of a word are buffered; the fourth arrives
    // on the same edge the word is written.
    always_comb begin
        state_d   = state;
        bi_d      = bi;
        wi_d      = wi;
        cnt_d     = cnt;
        asm_d     = asm_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;

        case (state)
            S_CNT0: begin
                if (accept) begin
                    cnt_d   = {8'h00, in_data};
                    state_d = S_CNT1;
                end
            end
            S_CNT1: begin
                if (accept) begin
                    cnt_d = n_rx;
                    bi_d  = 2'd0;
                    wi_d  = '0;
                    if ({1'b0, n_rx} > DEPTH_LIM) begin
                        state_d = S_ERR;
                    end else if (n_rx == 16'd0) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    case (bi)
                        2'd0: begin
                            asm_d[7:0] = in_data;
                            bi_d       = 2'd1;
                        end
                        2'd1: begin
                            asm_d[15:8] = in_data;
                            bi_d        = 2'd2;
                        end
                        2'd2: begin
                            asm_d[23:16] = in_data;
                            bi_d         = 2'd3;
                        end
                        default: begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = ADDR_W'({wi, 2'b00});
                            wr_data_d = {in_data, asm_q};
                            wi_d      = wi + 1'b1;
                            bi_d      = 2'd0;
                            if (last_word) begin
                                state_d = S_FIN;
                            end
                        end
                    endcase
                end
            end
            S_FIN:   state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_CNT0;
        endcase

        if (start) begin
            state_d = S_CNT0;
            bi_d    = 2'd0;
            wi_d    = '0;
            cnt_d   = 16'd0;
            asm_d   = 24'd0;
            wr_en_d = 1'b0;
        end
    end

    // Status flags follow the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bi       <= 2'd0;
            wi       <= '0;
            cnt      <= 16'd0;
            asm_q    <= 24'd0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 32'd0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            bi       <= bi_d;
            wi       <= wi_d;
            cnt      <= cnt_d;
            asm_q    <= asm_d;
            wr_en    <= wr_en_d;
            wr_addr  <= wr_addr_d;
            wr_data  <= wr_data_d;
            cpu_hold <= (state_d != S_DONE);
            done     <= (state_d == S_DONE);
            err      <= (state_d == S_ERR);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: randomized byte streams and handshake gaps checked
// against a word-level model of the expected memory writes and status timing.
module tb_imem_loader;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_hold;
    logic              done;
    logic              err;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    logic [7:0]  stim_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] wr_q[$];
    int          wr_cyc_q[$];
    int          acc4_q[$];
    logic        exp_err;
    int          exp_n;
    int          last_acc;
    int          hold_fall_cyc;
    int          done_cyc;
    int          err_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the DUT mid-cycle so registered outputs are stable.
    always @(negedge clk) begin
        if (rst) begin
            if (wr_en) begin
                wr_q.push_back({wr_addr, wr_data});
                wr_cyc_q.push_back(cyc);
            end
            if (!cpu_hold && hold_fall_cyc < 0) hold_fall_cyc = cyc;
            if (done && done_cyc < 0) done_cyc = cyc;
            if (err && err_cyc < 0) err_cyc = cyc;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic clear_monitor();
        wr_q.delete();
        wr_cyc_q.delete();
        acc4_q.delete();
        hold_fall_cyc = -1;
        done_cyc      = -1;
        err_cyc       = -1;
        last_acc      = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        checkOutput({tag, "_wr_en"},    64'(wr_en),    64'd0);
        checkOutput({tag, "_wr_addr"},  64'(wr_addr),  64'd0);
        checkOutput({tag, "_wr_data"},  64'(wr_data),  64'd0);
        checkOutput({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd1);
        checkOutput({tag, "_done"},     64'(done),     64'd0);
        checkOutput({tag, "_err"},      64'(err),      64'd0);
    endtask

    task automatic pulse_start();
        in_valid = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        clear_monitor();
    endtask

    // Reference: word k of the image lands at byte address 4k, little-endian.
    task automatic model();
        exp_q.delete();
        exp_n   = int'(stim_q[0]) + 256 * int'(stim_q[1]);
        exp_err = (exp_n > DEPTH);
        if (!exp_err) begin
            for (int k = 0; k < exp_n; k++) begin
                logic [31:0] word;
                word = {stim_q[2 + 4*k + 3], stim_q[2 + 4*k + 2],
                        stim_q[2 + 4*k + 1], stim_q[2 + 4*k]};
                exp_q.push_back({32'(4 * k), word});
            end
        end
    endtask

    task automatic applyStimulus(input int nbytes, input int valid_pct);
        for (int i = 0; i < nbytes; i++) begin
            int   waited;
            logic got;
            waited = 0;
            got    = 1'b0;
            while (!got && waited < 100) begin
                in_data  = stim_q[i];
                in_valid = ($urandom_range(99) < valid_pct);
                got      = in_valid && in_ready;
                @(posedge clk);
                #1;
                waited++;
            end
            in_valid = 1'b0;
            if (!got) begin
                checkOutput("accept_timeout", 64'd0, 64'd1);
                return;
            end
            last_acc = cyc;
            if (i >= 2 && ((i - 2) % 4) == 3) acc4_q.push_back(cyc);
        end
    endtask

    task automatic run_load(input string tag, input int valid_pct);
        int nbytes;
        model();
        nbytes = exp_err ? 2 : 2 + 4 * exp_n;
        applyStimulus(nbytes, valid_pct);
        repeat (4) @(posedge clk);
        #1;
        checkOutput({tag, "_wr_count"}, 64'(wr_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < wr_q.size() && k < exp_q.size(); k++) begin
            checkOutput($sformatf("%s_wr%0d", tag, k), wr_q[k], exp_q[k]);
            if (k < acc4_q.size())
                checkOutput($sformatf("%s_wr%0d_cycle", tag, k), 64'(wr_cyc_q[k]), 64'(acc4_q[k]));
        end
        if (exp_err) begin
            checkOutput({tag, "_err"},      64'(err),      64'd1);
            checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd0);
            checkOutput({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd1);
            checkOutput({tag, "_done"},     64'(done),     64'd0);
            checkOutput({tag, "_err_cycle"}, 64'(err_cyc), 64'(last_acc));
        end else begin
            checkOutput({tag, "_done"},     64'(done),     64'd1);
            checkOutput({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd0);
            checkOutput({tag, "_err"},      64'(err),      64'd0);
            checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd0);
            checkOutput({tag, "_done_cycle"}, 64'(done_cyc), 64'(last_acc + 1));
            checkOutput({tag, "_hold_cycle"}, 64'(hold_fall_cyc), 64'(last_acc + 1));
        end
    endtask

    task automatic load_plan_image();
        stim_q = '{8'h03, 8'h00,
                   8'h83, 8'h20, 8'h00, 8'h00,
                   8'h03, 8'h21, 8'h40, 8'h00,
                   8'h33, 8'hE2, 8'h20, 8'h00};
    endtask

    task automatic load_random_image(input int n);
        stim_q.delete();
        stim_q.push_back(8'(n));
        stim_q.push_back(8'(n >> 8));
        if (n <= DEPTH) begin
            for (int i = 0; i < 4 * n; i++) stim_q.push_back(8'($urandom));
        end
    endtask

    initial begin
        clear_monitor();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        clear_monitor();

        $display("[TB] plan image, continuous stream");
        load_plan_image();
        run_load("plan", 100);

        $display("[TB] plan image, gapped stream");
        pulse_start();
        load_plan_image();
        run_load("plan_gap", 55);

        $display("[TB] oversize count");
        pulse_start();
        stim_q = '{8'h41, 8'h00, 8'h11, 8'h22};
        run_load("oversize", 100);
        pulse_start();
        checkOutput("after_start_err",      64'(err),      64'd0);
        checkOutput("after_start_in_ready", 64'(in_ready), 64'd1);
        checkOutput("after_start_cpu_hold", 64'(cpu_hold), 64'd1);
        checkOutput("after_start_done",     64'(done),     64'd0);

        $display("[TB] zero count");
        stim_q = '{8'h00, 8'h00};
        run_load("zero", 70);

        $display("[TB] abort mid-word and reload");
        pulse_start();
        stim_q = '{8'h02, 8'h00, 8'hAA, 8'hBB};
        applyStimulus(4, 100);
        pulse_start();
        stim_q = '{8'h01, 8'h00, 8'h73, 8'h00, 8'h10, 8'h00};
        run_load("restart", 100);
        if (wr_q.size() > 0)
            checkOutput("restart_word", wr_q[0], {32'd0, 32'h0010_0073});

        $display("[TB] random images");
        for (int it = 0; it < 6; it++) begin
            pulse_start();
            load_random_image($urandom_range(1, 8));
            run_load($sformatf("rand%0d", it), $urandom_range(40, 100));
        end
        pulse_start();
        load_random_image(DEPTH);
        run_load("full_depth", 80);
        pulse_start();
        load_random_image(DEPTH + 1 + $urandom_range(0, 500));
        run_load("rand_oversize", 80);

        $display("[TB] reset mid-word");
        pulse_start();
        load_random_image(4);
        applyStimulus(8, 100);
        checkOutput("pre_reset_writes", 64'(wr_q.size()), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        clear_monitor();
        load_random_image(4);
        run_load("post_reset", 75);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
